// File: rtl/vga_pkg.sv
// vga_pkg: default 800x600@72 timing constants and the shared colour word.
package vga_pkg;
  localparam int VGA_H_VISIBLE = 800;
  localparam int VGA_H_FRONT   = 56;
  localparam int VGA_H_SYNC    = 120;
  localparam int VGA_H_BACK    = 64;
  localparam int VGA_V_VISIBLE = 600;
  localparam int VGA_V_FRONT   = 37;
  localparam int VGA_V_SYNC    = 6;
  localparam int VGA_V_BACK    = 23;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
  localparam bit VGA_SYNC_POL  = 1'b1;
  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } vga_color_t;
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage shift register, async active-low reset to RST_VAL.
module vga_delay_line #(
  parameter int W = 1,
  parameter int DEPTH = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [DEPTH-1:0][W-1:0] sr_q;
  if (DEPTH < 1) begin : g_depth_chk
    $error("vga_delay_line: DEPTH must be at least 1");
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) sr_q[k] <= RST_VAL;
    end else begin
      sr_q[0] <= d_i;
      for (int k = 1; k < DEPTH; k++) sr_q[k] <= sr_q[k-1];
    end
  end
  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster counters, frame-buffer indices and delayed syncs.
// Optional VGA_TIMING_FRAME_CNT_EN adds an 8-bit frame counter output.
module vga_timing_gen import vga_pkg::*; #(
  parameter int H_VISIBLE     = VGA_H_VISIBLE,
  parameter int H_FRONT       = VGA_H_FRONT,
  parameter int H_SYNC        = VGA_H_SYNC,
  parameter int H_BACK        = VGA_H_BACK,
  parameter int V_VISIBLE     = VGA_V_VISIBLE,
  parameter int V_FRONT       = VGA_V_FRONT,
  parameter int V_SYNC        = VGA_V_SYNC,
  parameter int V_BACK        = VGA_V_BACK,
  parameter int H_SCALE_SHIFT = 2,
  parameter int H_BITS        = 9,
  parameter int V_BITS        = 10,
  parameter int HC_BITS       = 11,
  parameter bit SYNC_POL      = VGA_SYNC_POL,
  parameter int SYNC_DELAY    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [H_BITS-1:0] h_index,
  output logic [V_BITS-1:0] v_index,
  output logic              h_porch,
  output logic              v_porch,
  output logic              display_en,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,output logic [7:0]       frame_cnt
`endif
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  if (H_TOTAL - 1 >= (1 << HC_BITS)) begin : g_hc_chk
    $error("vga_timing_gen: HC_BITS cannot hold H_TOTAL-1");
  end
  if (V_TOTAL - 1 >= (1 << V_BITS)) begin : g_vc_chk
    $error("vga_timing_gen: V_BITS cannot hold V_TOTAL-1");
  end
  localparam logic [HC_BITS-1:0] H_LAST = HC_BITS'(H_TOTAL - 1);
  localparam logic [HC_BITS-1:0] H_VIS  = HC_BITS'(H_VISIBLE);
  localparam logic [HC_BITS-1:0] HS_ON  = HC_BITS'(H_VISIBLE + H_FRONT);
  localparam logic [HC_BITS-1:0] HS_OFF = HC_BITS'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [V_BITS-1:0]  V_LAST = V_BITS'(V_TOTAL - 1);
  localparam logic [V_BITS-1:0]  V_VIS  = V_BITS'(V_VISIBLE);
  localparam logic [V_BITS-1:0]  VS_ON  = V_BITS'(V_VISIBLE + V_FRONT);
  localparam logic [V_BITS-1:0]  VS_OFF = V_BITS'(V_VISIBLE + V_FRONT + V_SYNC);
  // {hsync, vsync, display_en} idle levels
  localparam logic [2:0] SYNC_RST = {~SYNC_POL, ~SYNC_POL, 1'b0};
  logic [HC_BITS-1:0] h_cnt_q, h_cnt_d;
  logic [V_BITS-1:0]  v_cnt_q, v_cnt_d;
  logic [H_BITS-1:0]  h_index_q, h_index_d;
  logic [V_BITS-1:0]  v_index_q, v_index_d;
  logic               h_porch_q, v_porch_q, fs_q, fs_d;
  logic               h_blank, v_blank, hs_raw, vs_raw;
  logic [2:0]         sync1_q, sync1_d, sync_dly;
  always_comb begin
    h_cnt_d   = h_cnt_q == H_LAST ? '0 : h_cnt_q + 1'b1;
    v_cnt_d   = h_cnt_q != H_LAST ? v_cnt_q : v_cnt_q == V_LAST ? '0 : v_cnt_q + 1'b1;
    h_blank   = h_cnt_q >= H_VIS;
    v_blank   = v_cnt_q >= V_VIS;
    h_index_d = h_blank ? '0 : H_BITS'(h_cnt_q >> H_SCALE_SHIFT);
    v_index_d = v_blank ? '0 : v_cnt_q;
    fs_d      = h_cnt_q == '0 && v_cnt_q == '0;
    hs_raw    = (h_cnt_q >= HS_ON && h_cnt_q < HS_OFF) ? SYNC_POL : ~SYNC_POL;
    vs_raw    = (v_cnt_q >= VS_ON && v_cnt_q < VS_OFF) ? SYNC_POL : ~SYNC_POL;
    sync1_d   = {hs_raw, vs_raw, ~h_blank & ~v_blank};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      h_index_q <= '0;
      v_index_q <= '0;
      h_porch_q <= 1'b0;
      v_porch_q <= 1'b0;
      fs_q      <= 1'b0;
      sync1_q   <= SYNC_RST;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      h_index_q <= h_index_d;
      v_index_q <= v_index_d;
      h_porch_q <= h_blank;
      v_porch_q <= v_blank;
      fs_q      <= fs_d;
      sync1_q   <= sync1_d;
    end
  end
  // Syncs and display_en trail the indices by the frame buffer's read latency
  vga_delay_line #(.W(3), .DEPTH(SYNC_DELAY), .RST_VAL(SYNC_RST)) u_sync_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sync1_q),
    .q_o   (sync_dly)
  );
  assign h_index     = h_index_q;
  assign v_index     = v_index_q;
  assign h_porch     = h_porch_q;
  assign v_porch     = v_porch_q;
  assign frame_start = fs_q;
  assign {hsync, vsync, display_en} = sync_dly;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else frame_cnt_q <= frame_cnt_q + {7'd0, fs_q};
  end
  assign frame_cnt = frame_cnt_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random-length runs and random async resets against a position-arithmetic model.
module tb_vga_timing_gen;
  localparam int HV = 16, HF = 3, HS = 4, HB = 5;
  localparam int VV = 10, VF = 2, VS = 3, VB = 2;
  localparam int SH = 2, SD = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] h_index;
  logic [9:0] v_index;
  logic       h_porch, v_porch, display_en, hsync, vsync, frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif
  int k = 0;
  int vectors = 0;
  int errors = 0;
  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SCALE_SHIFT(SH), .H_BITS(9), .V_BITS(10), .HC_BITS(11),
    .SYNC_POL(1'b1), .SYNC_DELAY(SD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .h_index(h_index), .v_index(v_index),
    .h_porch(h_porch), .v_porch(v_porch), .display_en(display_en),
    .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask
  // k = clock edges since reset release; stage 1 shows raster position k-1,
  // syncs show position k-1-SD.
  task automatic check_all();
    int p, h, v, q, hq, vq;
    int e_hi = 0, e_vi = 0, e_hp = 0, e_vp = 0, e_fs = 0, e_hs = 0, e_vs = 0, e_de = 0;
    if (k > 0) begin
      p = k - 1;
      h = p % HT;
      v = (p / HT) % VT;
      e_hp = int'(h >= HV);
      e_vp = int'(v >= VV);
      e_hi = h < HV ? h / (1 << SH) : 0;
      e_vi = v < VV ? v : 0;
      e_fs = int'(h == 0 && v == 0);
      q = k - 1 - SD;
      if (q >= 0) begin
        hq = q % HT;
        vq = (q / HT) % VT;
        e_hs = int'(hq >= HV + HF && hq < HV + HF + HS);
        e_vs = int'(vq >= VV + VF && vq < VV + VF + VS);
        e_de = int'(hq < HV && vq < VV);
      end
    end
    chk("h_index", 32'(h_index), 32'(e_hi));
    chk("v_index", 32'(v_index), 32'(e_vi));
    chk("h_porch", 32'(h_porch), 32'(e_hp));
    chk("v_porch", 32'(v_porch), 32'(e_vp));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("hsync", 32'(hsync), 32'(e_hs));
    chk("vsync", 32'(vsync), 32'(e_vs));
    chk("display_en", 32'(display_en), 32'(e_de));
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("frame_cnt", 32'(frame_cnt), 32'(k == 0 ? 0 : ((k - 1 + FT - 1) / FT) % 256));
`endif
  endtask
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      check_all();
    end
  endtask
  initial begin
    repeat (5) begin
      @(negedge clk);
      check_all();
    end
    rst_n = 1'b1;
    run(2 * FT + 40);
    for (int r = 0; r < 4; r++) begin
      run(int'($urandom_range(1, FT)));
      @(posedge clk);
      #3 rst_n = 1'b0;
      k = 0;
      #1 check_all();
      repeat (int'($urandom_range(1, 4))) begin
        @(negedge clk);
        check_all();
      end
      rst_n = 1'b1;
      run(FT + 60);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
